// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard tracker.
// An entry is one in-flight writer: destination register plus cycles until its result exists.
package hazard_pkg;

  localparam logic [2:0] TUSE_NONE = 3'd5;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef struct packed {
    logic [4:0] dst;
    logic [2:0] tnew;
  } entry_t;

  localparam entry_t BUBBLE = '{dst: 5'd0, tnew: 3'd0};

  // Saturating decrement; a finished result stays finished.
  function automatic logic [2:0] dec(input logic [2:0] x);
    return (x == 3'd0) ? 3'd0 : x - 3'd1;
  endfunction

endpackage

// File: rtl/hazard_operand_check.sv
// Stall term and forwarding select for one D-stage source operand
// against the E/M/W shadow entries.
module hazard_operand_check
  import hazard_pkg::*;
(
  input  logic [4:0] i_idx,
  input  logic [2:0] i_tuse,
  input  entry_t     i_ent_e,
  input  entry_t     i_ent_m,
  input  entry_t     i_ent_w,
  output logic       o_stall_term,
  output logic [1:0] o_fwd_sel
);

  logic w_nz;
  logic w_hit_e;
  logic w_hit_m;
  logic w_hit_w;

  assign w_nz    = (i_idx != 5'd0);
  assign w_hit_e = w_nz && (i_ent_e.dst == i_idx);
  assign w_hit_m = w_nz && (i_ent_m.dst == i_idx);
  assign w_hit_w = w_nz && (i_ent_w.dst == i_idx);

  // W results are always ready, so only E and M can hold the consumer back.
  assign o_stall_term = (w_hit_e && (i_tuse < i_ent_e.tnew)) ||
                        (w_hit_m && (i_tuse < i_ent_m.tnew));

  // Youngest match wins even when it is not ready yet; older copies are stale.
  always_comb begin
    o_fwd_sel = FWD_RF;
    if (w_hit_e) begin
      if (i_ent_e.tnew == 3'd0) o_fwd_sel = FWD_E;
    end else if (w_hit_m) begin
      if (i_ent_m.tnew == 3'd0) o_fwd_sel = FWD_M;
    end else if (w_hit_w) begin
      if (i_ent_w.tnew == 3'd0) o_fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// Five-stage pipeline hazard tracker: shadow E/M/W writer entries, D-stage stall
// generation (data and mul/div busy) and per-operand forwarding selects.
module hazard_tracker
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [2:0] d_tuse_rs,
  input  logic [2:0] d_tuse_rt,
  input  logic [2:0] d_tnew,
  input  logic [4:0] d_dst,
  input  logic       d_is_md,
  input  logic       md_busy,
  output logic       stall,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel
);

  entry_t r_ent_e;
  entry_t r_ent_m;
  entry_t r_ent_w;

  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_md;

  hazard_operand_check u_chk_rs (
    .i_idx        (d_rs),
    .i_tuse       (d_tuse_rs),
    .i_ent_e      (r_ent_e),
    .i_ent_m      (r_ent_m),
    .i_ent_w      (r_ent_w),
    .o_stall_term (w_stall_rs),
    .o_fwd_sel    (fwd_rs_sel)
  );

  hazard_operand_check u_chk_rt (
    .i_idx        (d_rt),
    .i_tuse       (d_tuse_rt),
    .i_ent_e      (r_ent_e),
    .i_ent_m      (r_ent_m),
    .i_ent_w      (r_ent_w),
    .o_stall_term (w_stall_rt),
    .o_fwd_sel    (fwd_rt_sel)
  );

  assign w_stall_md = d_is_md & md_busy;
  // A flushed D instruction is discarded anyway, so holding it would only waste a cycle.
  assign stall      = (w_stall_rs | w_stall_rt | w_stall_md) & ~flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_ent_e <= BUBBLE;
      r_ent_m <= BUBBLE;
      r_ent_w <= BUBBLE;
    end else begin
      if (stall) begin
        r_ent_e <= BUBBLE;
      end else begin
        r_ent_e <= '{dst: d_dst, tnew: dec(d_tnew)};
      end
      r_ent_m <= '{dst: r_ent_e.dst, tnew: dec(r_ent_e.tnew)};
      r_ent_w <= '{dst: r_ent_m.dst, tnew: dec(r_ent_m.tnew)};
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed scoreboard bench for hazard_tracker: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_hazard_tracker;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [2:0] d_tuse_rs;
  logic [2:0] d_tuse_rt;
  logic [2:0] d_tnew;
  logic [4:0] d_dst;
  logic       d_is_md;
  logic       md_busy;
  logic       stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;

  always #5 clk = ~clk;

  hazard_tracker dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_tnew     (d_tnew),
    .d_dst      (d_dst),
    .d_is_md    (d_is_md),
    .md_busy    (md_busy),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel)
  );

  typedef struct {
    string      name;
    bit         cs;
    logic       s;
    bit         csel;
    logic [1:0] r;
    logic [1:0] t;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.cs) begin
        checks++;
        if (stall !== e.s) begin
          failures++;
          $display("FAIL %s stall actual=%0b required=%0b", e.name, stall, e.s);
        end
      end
      if (e.csel) begin
        checks++;
        if (fwd_rs_sel !== e.r) begin
          failures++;
          $display("FAIL %s fwd_rs_sel actual=%0d required=%0d", e.name, fwd_rs_sel, e.r);
        end
        checks++;
        if (fwd_rt_sel !== e.t) begin
          failures++;
          $display("FAIL %s fwd_rt_sel actual=%0d required=%0d", e.name, fwd_rt_sel, e.t);
        end
      end
    end
  end

  task automatic set_d(input logic [4:0] rs, input logic [2:0] urs,
                       input logic [4:0] rt, input logic [2:0] urt,
                       input logic [4:0] dst, input logic [2:0] tn);
    d_rs      = rs;
    d_tuse_rs = urs;
    d_rt      = rt;
    d_tuse_rt = urt;
    d_dst     = dst;
    d_tnew    = tn;
  endtask

  task automatic nop();
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 3'd0);
    d_is_md = 1'b0;
    md_busy = 1'b0;
  endtask

  task automatic exp_stall(input string n, input logic s);
    exp_t e;
    e.name = n; e.cs = 1'b1; e.s = s; e.csel = 1'b0; e.r = 2'd0; e.t = 2'd0;
    sb_q.push_back(e);
  endtask

  task automatic exp_all(input string n, input logic s, input logic [1:0] r, input logic [1:0] t);
    exp_t e;
    e.name = n; e.cs = 1'b1; e.s = s; e.csel = 1'b1; e.r = r; e.t = t;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // after reset every entry is a bubble
    set_d(5'd8, 3'd0, 5'd9, 3'd0, 5'd0, 3'd0);
    exp_all("reset", 1'b0, FWD_RF, FWD_RF);
    tick();
    drain();

    // lw $8 ; addu $9,$8,$1
    set_d(5'd1, 3'd1, 5'd0, TUSE_NONE, 5'd8, 3'd3);
    exp_stall("lu_issue", 1'b0);
    tick();
    set_d(5'd8, 3'd1, 5'd1, 3'd1, 5'd9, 3'd2);
    exp_stall("lu_c1", 1'b1);
    tick();
    exp_stall("lu_c2", 1'b0);
    tick();
    // load now in W, addu in E
    set_d(5'd8, 3'd1, 5'd9, 3'd2, 5'd0, 3'd0);
    exp_all("lu_c3", 1'b0, FWD_W, FWD_RF);
    tick();
    drain();

    // addu $8 ; beq $8,$0
    set_d(5'd2, 3'd1, 5'd3, 3'd1, 5'd8, 3'd2);
    exp_stall("alu_issue", 1'b0);
    tick();
    set_d(5'd8, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0);
    exp_stall("alu_c1", 1'b1);
    tick();
    exp_all("alu_c2", 1'b0, FWD_M, FWD_RF);
    tick();
    set_d(5'd8, 3'd0, 5'd0, TUSE_NONE, 5'd0, 3'd0);
    exp_all("alu_w", 1'b0, FWD_W, FWD_RF);
    tick();
    drain();

    // addu $5 then lw $5: E holds the load, M the stale ALU value
    set_d(5'd1, 3'd1, 5'd2, 3'd1, 5'd5, 3'd2);
    tick();
    set_d(5'd6, 3'd1, 5'd0, TUSE_NONE, 5'd5, 3'd3);
    exp_stall("same_lw", 1'b0);
    tick();
    set_d(5'd5, 3'd2, 5'd0, TUSE_NONE, 5'd10, 3'd2);
    exp_all("same_c1", 1'b0, FWD_RF, FWD_RF);
    tick();
    set_d(5'd5, 3'd2, 5'd0, TUSE_NONE, 5'd0, 3'd0);
    exp_all("same_c2", 1'b0, FWD_RF, FWD_RF);
    tick();
    set_d(5'd5, 3'd2, 5'd10, 3'd0, 5'd0, 3'd0);
    exp_all("same_c3", 1'b0, FWD_W, FWD_M);
    tick();
    drain();

    // register 0 and unused operand against a fresh load in E
    set_d(5'd1, 3'd1, 5'd0, TUSE_NONE, 5'd8, 3'd3);
    tick();
    set_d(5'd0, 3'd0, 5'd8, TUSE_NONE, 5'd0, 3'd0);
    exp_all("zero_unused", 1'b0, FWD_RF, FWD_RF);
    tick();
    drain();

    // writer whose result is ready in E
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd7, 3'd1);
    tick();
    set_d(5'd7, 3'd1, 5'd7, 3'd0, 5'd0, 3'd0);
    exp_all("fwd_e", 1'b0, FWD_E, FWD_E);
    tick();
    drain();

    // mul/div busy
    nop();
    md_busy = 1'b1;
    exp_stall("md_not_md", 1'b0);
    tick();
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd3, 3'd2);
    d_is_md = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_stall("md_busy", 1'b1);
      tick();
    end
    md_busy = 1'b0;
    exp_stall("md_release", 1'b0);
    tick();
    drain();

    // flush during a load-use stall
    set_d(5'd1, 3'd1, 5'd0, TUSE_NONE, 5'd8, 3'd3);
    tick();
    set_d(5'd8, 3'd0, 5'd8, 3'd0, 5'd9, 3'd2);
    flush = 1'b1;
    exp_stall("flush_forced", 1'b0);
    tick();
    flush = 1'b0;
    exp_all("flush_after", 1'b0, FWD_RF, FWD_RF);
    tick();
    drain();

    // reset during a load-use stall
    set_d(5'd1, 3'd1, 5'd0, TUSE_NONE, 5'd8, 3'd3);
    tick();
    set_d(5'd8, 3'd0, 5'd8, 3'd0, 5'd9, 3'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_all("reset_after", 1'b0, FWD_RF, FWD_RF);
    tick();
    drain();

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
